calc_n: RTL and testbench
=========================

Name: calc_n

Overview:
- Parametrised successor to the four-port calc1 calculator: NUM_PORTS request ports, DATA_W-bit operands, and one shared ALU.
- The ALU is arbitrated round-robin and adds per-port busy backpressure.
- Each port uses the same two-cycle command/operand protocol and the same response codes as calc1.
- Sits in the calculator subsystem as a drop-in core for wider or more heavily loaded configurations.

Parameters:
NUM_PORTS, 4, number of request/response ports (1..8)
DATA_W, 32, operand/result width in bits (8..64, power of two)
SHW, $clog2(DATA_W), shift-amount width, derived; do not override

Ports:
c_clk  input  1  clock; all logic is rising-edge
reset  input  1  asynchronous, active-low reset; internal release is synchronous to c_clk
req_cmd_in  input  4*NUM_PORTS  per-port command; port p uses bits [4p+3:4p]
req_data_in  input  DATA_W*NUM_PORTS  per-port operand bus
out_resp  output  2*NUM_PORTS  per-port response code
out_data  output  DATA_W*NUM_PORTS  per-port result
req_busy  output  NUM_PORTS  per-port busy flag; a command presented while it is high is ignored

Behaviour:
- Reset (reset=0): all out_resp=0, out_data=0, req_busy=0, every port FSM in IDLE, round-robin pointer=0. Assertion mid-operation discards all in-flight requests; no stale response after release.
- Commands:
  - 0 = no-op
  - 1 = add
  - 2 = subtract (op1-op2)
  - 5 = shift left logical
  - 6 = shift right logical
  - any other nonzero value = invalid
- Response codes:
  - 0 = none
  - 1 = success
  - 2 = overflow/underflow
  - 3 = invalid command
- Request protocol, per port, cycle T: req_cmd_in≠0 with op1 on req_data_in, sampled only when req_busy=0.
- Cycle T+1: req_data_in = op2, always captured, including for invalid commands. req_cmd_in is don't-care in T+1.
- Per-port FSM:
  - IDLE --cmd≠0 & !busy--> CAPT
  - CAPT --(1 cycle)--> PEND
  - PEND --grant--> EXEC
  - EXEC --> RESP
  - RESP --> IDLE
  - req_busy=1 in CAPT, PEND, EXEC and RESP.
- Arbitration: at most one PEND port is granted per cycle. Search starts at the port after the last granted, wrapping at NUM_PORTS-1→0; after reset the search starts at port 0. Grant takes effect the cycle after entry to PEND at the earliest.
- Latency: uncontended, out_resp/out_data are valid in cycle T+3, held exactly one cycle, then return to 0. Under contention each extra cycle spent waiting in PEND adds one cycle.
- A new command is accepted in the cycle after RESP (T+4 uncontended). Responses to other ports may coincide in time, but at most one new result per cycle.
- Arithmetic (widths are DATA_W):
  - Add: carry out of the MSB → resp 2, data 0; else resp 1, data = sum.
  - Sub: op2 > op1 (unsigned) → resp 2, data 0; else resp 1, data = difference. op1 == op2 → resp 1, data 0.
  - Shift left: op1 << op2[SHW-1:0], bits shifted out are discarded, zero fill, resp 1. Upper bits of op2 are ignored.
  - Shift right: same rules, logical, zero fill.
  - Invalid: resp 3, data 0; the command still passes through arbitration.
- out_data is 0 whenever out_resp=0.
- Ports are independent: a busy port never blocks acceptance on another port.

Test Plan:
- Reset held low 4 cycles with random inputs → all outputs 0. Release, port0 cmd1 op1=0x0000_0001, op2=0x01FF_FFFF → out_resp0=1, out_data0=0x0200_0000 exactly at T+3, one cycle wide.
- Port0 add 0xFFFF_FFFF+1 → resp 2, data 0. Port0 sub 0x1-0xF → resp 2, data 0. Sub 0x5-0x5 → resp 1, data 0. Repeat the add with DATA_W=16: 0xFFFF+1 → resp 2.
- Shifts: cmd5 op1=1, op2=4 → 0x10. cmd5 op1=1, op2=33 (shift 1) → 0x2. cmd6 op1=0x8000_0000, op2=31 → 0x1. All resp 1.
- Invalid commands 3, 4 and 15 on port2 → resp 3, data 0 at T+3. Port accepts a new command at T+4.
- All 4 ports issue add k+k (k = port index) in the same cycle → responses ports 0,1,2,3 at T+3..T+6, data 0,2,4,6. Immediately repeat on ports 1..3 only → order 1,2,3 (rotating pointer). Commands driven while req_busy=1 produce no response.
- Reset asserted while 3 ports are in PEND → outputs 0 immediately (asynchronous). After release, no response appears within 10 cycles, and the next request behaves as in the first scenario.

Source files
------------

// File: rtl/calc_n.sv
// -----------------------------------------------------------------------------
// calc_n : multi-port calculator core with one shared ALU
//
// Each of NUM_PORTS ports issues a two-cycle request. In the first cycle it
// presents a command with op1, and in the second cycle it presents op2. The
// port then waits for a round-robin grant on the single ALU. The result is
// presented for exactly one cycle. req_busy stays high from the cycle after
// the command is accepted until the response cycle ends.
//
// Ports
//   c_clk        in   rising-edge clock
//   reset        in   async active-low reset (release synchronised to c_clk)
//   req_cmd_in   in   [4*NUM_PORTS]      per-port command, port p at [4p+3:4p]
//   req_data_in  in   [DATA_W*NUM_PORTS] per-port operand (op1, then op2)
//   out_resp     out  [2*NUM_PORTS]      per-port response code
//   out_data     out  [DATA_W*NUM_PORTS] per-port result (0 when out_resp=0)
//   req_busy     out  [NUM_PORTS]        per-port busy; commands ignored when 1
// -----------------------------------------------------------------------------
module calc_n #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int SHW       = $clog2(DATA_W)
) (
  input  logic                          c_clk,
  input  logic                          reset,
  input  logic [4*NUM_PORTS-1:0]        req_cmd_in,
  input  logic [DATA_W*NUM_PORTS-1:0]   req_data_in,
  output logic [2*NUM_PORTS-1:0]        out_resp,
  output logic [DATA_W*NUM_PORTS-1:0]   out_data,
  output logic [NUM_PORTS-1:0]          req_busy
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_OK  = 2'd1;
  localparam logic [1:0] RESP_OVF = 2'd2;
  localparam logic [1:0] RESP_INV = 2'd3;

  // The execute step is the PEND cycle in which the port wins the grant.
  // The ALU result is registered at the end of that cycle, so RESP is the
  // cycle in which the response is visible on the outputs.
  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPT,
    S_PEND,
    S_RESP
  } state_e;

  // ---------------------------------------------------------------------------
  // Reset synchroniser: assertion is immediate, release waits two clock edges
  // ---------------------------------------------------------------------------
  logic r_rst_meta;
  logic r_rst_sync;
  logic w_rst_n;

  // NOTE: every clocked block uses non-blocking assignments, so all flops
  // sample their pre-edge values and simulation matches the synthesised logic.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst_n = r_rst_sync;

  // ---------------------------------------------------------------------------
  // Per-port unpacking of the flat buses
  // ---------------------------------------------------------------------------
  logic [3:0]        w_cmd_in  [NUM_PORTS];
  logic [DATA_W-1:0] w_data_in [NUM_PORTS];

  state_e            r_state [NUM_PORTS];
  logic [3:0]        r_cmd   [NUM_PORTS];
  logic [DATA_W-1:0] r_op1   [NUM_PORTS];
  logic [DATA_W-1:0] r_op2   [NUM_PORTS];
  logic [1:0]        r_resp  [NUM_PORTS];
  logic [DATA_W-1:0] r_data  [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign w_cmd_in[g]                    = req_cmd_in[4*g +: 4];
    assign w_data_in[g]                   = req_data_in[DATA_W*g +: DATA_W];
    assign out_resp[2*g +: 2]             = r_resp[g];
    assign out_data[DATA_W*g +: DATA_W]   = r_data[g];
    assign req_busy[g]                    = (r_state[g] != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: scan starts at r_ptr (the port after the last grant)
  // ---------------------------------------------------------------------------
  logic [PW-1:0]        r_ptr;
  logic [PW:0]          w_scan;
  logic                 w_gnt_valid;
  logic [PW-1:0]        w_gnt_idx;
  logic [NUM_PORTS-1:0] w_gnt_vec;
  logic [PW-1:0]        w_ptr_nxt;

  // NOTE: every signal driven from always_comb gets a default value first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    w_scan      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_scan = {1'b0, r_ptr} + (PW+1)'(i);
      if (w_scan >= (PW+1)'(NUM_PORTS)) begin
        w_scan = w_scan - (PW+1)'(NUM_PORTS);
      end
      if (!w_gnt_valid && (r_state[w_scan[PW-1:0]] == S_PEND)) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = w_scan[PW-1:0];
      end
    end
  end

  always_comb begin
    w_gnt_vec = '0;
    if (w_gnt_valid) begin
      w_gnt_vec[w_gnt_idx] = 1'b1;
    end
  end

  assign w_ptr_nxt = (w_gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : w_gnt_idx + 1'b1;

  // ---------------------------------------------------------------------------
  // Shared ALU, fed by the granted port's captured request
  // ---------------------------------------------------------------------------
  logic [3:0]        w_cmd;
  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_op2;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_diff;
  logic [1:0]        w_alu_resp;
  logic [DATA_W-1:0] w_alu_data;

  assign w_cmd  = r_cmd[w_gnt_idx];
  assign w_op1  = r_op1[w_gnt_idx];
  assign w_op2  = r_op2[w_gnt_idx];
  assign w_sum  = {1'b0, w_op1} + {1'b0, w_op2};
  assign w_diff = w_op1 - w_op2;

  always_comb begin
    w_alu_resp = RESP_INV;
    w_alu_data = '0;
    case (w_cmd)
      CMD_ADD: begin
        if (w_sum[DATA_W]) begin
          w_alu_resp = RESP_OVF;
        end else begin
          w_alu_resp = RESP_OK;
          w_alu_data = w_sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (w_op2 > w_op1) begin
          w_alu_resp = RESP_OVF;
        end else begin
          w_alu_resp = RESP_OK;
          w_alu_data = w_diff;
        end
      end
      // Only the low SHW bits of op2 select the shift amount.
      CMD_SHL: begin
        w_alu_resp = RESP_OK;
        w_alu_data = w_op1 << w_op2[SHW-1:0];
      end
      CMD_SHR: begin
        w_alu_resp = RESP_OK;
        w_alu_data = w_op1 >> w_op2[SHW-1:0];
      end
      default: begin
        w_alu_resp = RESP_INV;
        w_alu_data = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand capture
  // ---------------------------------------------------------------------------
  // NOTE: the operand storage has no reset. It is only read after the port
  // FSM (which is reset) has written it, so resetting it would only add
  // reset fan-out.
  always_ff @(posedge c_clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if ((r_state[p] == S_IDLE) && (w_cmd_in[p] != 4'd0)) begin
        r_cmd[p] <= w_cmd_in[p];
        r_op1[p] <= w_data_in[p];
      end
      // op2 is taken in the second request cycle for every command, invalid
      // ones included.
      if (r_state[p] == S_CAPT) begin
        r_op2[p] <= w_data_in[p];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Port FSMs, arbitration pointer and registered responses
  // ---------------------------------------------------------------------------
  always_ff @(posedge c_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ptr <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_state[p] <= S_IDLE;
        r_resp[p]  <= '0;
        r_data[p]  <= '0;
      end
    end else begin
      if (w_gnt_valid) begin
        r_ptr <= w_ptr_nxt;
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        // A response is held for exactly one cycle and is cleared otherwise.
        if (w_gnt_vec[p]) begin
          r_resp[p] <= w_alu_resp;
          r_data[p] <= w_alu_data;
        end else begin
          r_resp[p] <= '0;
          r_data[p] <= '0;
        end

        case (r_state[p])
          S_IDLE:  if (w_cmd_in[p] != 4'd0) r_state[p] <= S_CAPT;
          S_CAPT:  r_state[p] <= S_PEND;
          S_PEND:  if (w_gnt_vec[p]) r_state[p] <= S_RESP;
          S_RESP:  r_state[p] <= S_IDLE;
          default: r_state[p] <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_n.sv
// -----------------------------------------------------------------------------
// tb_calc_n : directed, table-driven bench for calc_n
//
// The main instance uses NUM_PORTS=4 and DATA_W=32. A second instance uses
// NUM_PORTS=2 and DATA_W=16 to exercise the narrow-width overflow case.
// -----------------------------------------------------------------------------
module tb_calc_n;

  logic         c_clk;
  logic         reset;

  logic [15:0]  cmd;
  logic [127:0] din;
  logic [7:0]   resp;
  logic [127:0] dout;
  logic [3:0]   busy;

  logic [7:0]   cmd2;
  logic [31:0]  din2;
  logic [3:0]   resp2;
  logic [31:0]  dout2;
  logic [1:0]   busy2;

  int total;
  int bad;

  calc_n #(.NUM_PORTS(4), .DATA_W(32)) u_dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (cmd),
    .req_data_in (din),
    .out_resp    (resp),
    .out_data    (dout),
    .req_busy    (busy)
  );

  calc_n #(.NUM_PORTS(2), .DATA_W(16)) u_dut16 (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (cmd2),
    .req_data_in (din2),
    .out_resp    (resp2),
    .out_data    (dout2),
    .req_busy    (busy2)
  );

  initial begin
    c_clk = 1'b0;
    forever #5 c_clk = ~c_clk;
  end

  typedef struct {
    int          port;
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  resp;
    logic [31:0] data;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  // One uncontended request on the wide instance.
  // Returns in cycle T+4, when the port must accept again.
  task automatic run_single(input vec_t v, input int id);
    logic [7:0]   e_resp;
    logic [127:0] e_data;
    logic [3:0]   e_busy;
    e_resp = '0;
    e_data = '0;
    e_busy = '0;
    e_resp[2*v.port +: 2]  = v.resp;
    e_data[32*v.port +: 32] = v.data;
    e_busy[v.port]         = 1'b1;

    cmd = '0; din = '0;
    cmd[4*v.port +: 4]   = v.cmd;
    din[32*v.port +: 32] = v.op1;
    tick();                                               // T+1
    check($sformatf("v%0d_busy_t1", id), {124'd0, busy}, {124'd0, e_busy});
    cmd = '0;
    din[32*v.port +: 32] = v.op2;
    tick();                                               // T+2
    check($sformatf("v%0d_resp_t2", id), {120'd0, resp}, 128'd0);
    din = '0;
    tick();                                               // T+3
    check($sformatf("v%0d_resp_t3", id), {120'd0, resp}, {120'd0, e_resp});
    check($sformatf("v%0d_data_t3", id), dout, e_data);
    tick();                                               // T+4
    check($sformatf("v%0d_resp_t4", id), {120'd0, resp}, 128'd0);
    check($sformatf("v%0d_busy_t4", id), {124'd0, busy}, 128'd0);
  endtask

  // Add k+off to itself on every port k in mask. This returns in T+2.
  // With junk set, commands are also driven on the masked (busy) ports in
  // T+1 and T+2. These commands must be ignored.
  task automatic issue_add(input logic [3:0] mask, input int off, input bit junk);
    cmd = '0; din = '0;
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) begin
        cmd[4*k +: 4]   = 4'd1;
        din[32*k +: 32] = 32'(k + off);
      end
    end
    tick();                                               // T+1
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) cmd[4*k +: 4] = junk ? 4'hF : 4'h0;
    end
    tick();                                               // T+2
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) begin
        cmd[4*k +: 4]   = junk ? 4'h1 : 4'h0;
        din[32*k +: 32] = junk ? 32'hDEAD_BEEF : 32'h0;
      end
    end
  endtask

  // Called in T+2. The n responses are expected in T+3.. in the given port
  // order. Each result is 2*(port+off).
  task automatic expect_order(input string tag, input int n, input int p0, input int p1,
                              input int p2, input int p3, input int off);
    int           ord [4];
    logic [7:0]   e_resp;
    logic [127:0] e_data;
    ord = '{p0, p1, p2, p3};
    check({tag, "_t2"}, {120'd0, resp}, 128'd0);
    for (int j = 0; j < n; j++) begin
      tick();
      e_resp = '0;
      e_data = '0;
      e_resp[2*ord[j] +: 2]   = 2'd1;
      e_data[32*ord[j] +: 32] = 32'(2 * (ord[j] + off));
      check($sformatf("%s_resp%0d", tag, j), {120'd0, resp}, {120'd0, e_resp});
      check($sformatf("%s_data%0d", tag, j), dout, e_data);
      if (j == 0) begin
        cmd = '0;
        din = '0;
      end
    end
    tick();
    check({tag, "_resp_end"}, {120'd0, resp}, 128'd0);
    check({tag, "_busy_end"}, {124'd0, busy}, 128'd0);
  endtask

  // One request on port 0 of the 16-bit instance.
  task automatic run16(input string name, input logic [3:0] c, input logic [15:0] a,
                       input logic [15:0] b, input logic [1:0] r, input logic [15:0] d);
    cmd2 = {4'h0, c};
    din2 = {16'h0, a};
    tick();
    cmd2 = '0;
    din2 = {16'h0, b};
    tick();
    check({name, "_t2"}, {124'd0, resp2}, 128'd0);
    din2 = '0;
    tick();
    check({name, "_resp"}, {124'd0, resp2}, {126'd0, r});
    check({name, "_data"}, {96'd0, dout2}, {112'd0, d});
    tick();
    check({name, "_idle"}, {124'd0, resp2, 2'b00, busy2}, 128'd0);
  endtask

  initial begin
    vec_t tbl [12];

    total = 0;
    bad   = 0;
    cmd   = '0;
    din   = '0;
    cmd2  = '0;
    din2  = '0;
    reset = 1'b0;

    tbl[0]  = '{0, 4'd1,  32'h0000_0001, 32'h01FF_FFFF, 2'd1, 32'h0200_0000};
    tbl[1]  = '{0, 4'd1,  32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0};
    tbl[2]  = '{0, 4'd2,  32'h0000_0001, 32'h0000_000F, 2'd2, 32'h0};
    tbl[3]  = '{0, 4'd2,  32'h0000_0005, 32'h0000_0005, 2'd1, 32'h0};
    tbl[4]  = '{0, 4'd5,  32'h0000_0001, 32'h0000_0004, 2'd1, 32'h0000_0010};
    tbl[5]  = '{0, 4'd5,  32'h0000_0001, 32'd33,        2'd1, 32'h0000_0002};
    tbl[6]  = '{0, 4'd6,  32'h8000_0000, 32'd31,        2'd1, 32'h0000_0001};
    tbl[7]  = '{2, 4'd3,  32'h1234_5678, 32'h0000_0001, 2'd3, 32'h0};
    tbl[8]  = '{2, 4'd4,  32'h0000_0001, 32'h0000_0001, 2'd3, 32'h0};
    tbl[9]  = '{2, 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd3, 32'h0};
    tbl[10] = '{1, 4'd2,  32'h0000_0100, 32'h0000_0001, 2'd1, 32'h0000_00FF};
    // Keep port 3 last, so the round-robin pointer wraps to port 0 before
    // the contention test.
    tbl[11] = '{3, 4'd1,  32'h7FFF_FFFF, 32'h0000_0001, 2'd1, 32'h8000_0000};

    // Reset is held low with random inputs, and every output stays 0.
    for (int i = 0; i < 4; i++) begin
      cmd  = 16'($urandom);
      din  = {$urandom, $urandom, $urandom, $urandom};
      cmd2 = 8'($urandom);
      din2 = $urandom;
      tick();
      check($sformatf("rst_resp%0d", i), {120'd0, resp}, 128'd0);
      check($sformatf("rst_data%0d", i), dout, 128'd0);
      check($sformatf("rst_busy%0d", i), {124'd0, busy}, 128'd0);
    end
    cmd = '0; din = '0; cmd2 = '0; din2 = '0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // Directed single-request vectors.
    for (int i = 0; i < 12; i++) begin
      run_single(tbl[i], i);
    end

    // Narrow instance.
    run16("w16_ovf", 4'd1, 16'hFFFF, 16'h0001, 2'd2, 16'h0000);
    run16("w16_add", 4'd1, 16'h7FFF, 16'h0001, 2'd1, 16'h8000);
    run16("w16_shl", 4'd5, 16'h0001, 16'd17,   2'd1, 16'h0002);

    // All four ports issue together. Busy-port commands are ignored.
    issue_add(4'b1111, 0, 1'b1);
    expect_order("all4", 4, 0, 1, 2, 3, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("all4_quiet%0d", i), {120'd0, resp}, 128'd0);
    end

    // Ports 1..3 only: the pointer is back at 0.
    issue_add(4'b1110, 1, 1'b0);
    expect_order("p123", 3, 1, 2, 3, 0, 1);

    // A grant to port 2 moves the pointer to 3, so port 3 now beats port 0.
    run_single('{2, 4'd1, 32'd5, 32'd6, 2'd1, 32'd11}, 20);
    issue_add(4'b1001, 2, 1'b0);
    expect_order("rot", 2, 3, 0, 0, 0, 2);

    // Reset mid-operation while ports 0..2 are pending.
    issue_add(4'b0111, 0, 1'b0);
    #1 reset = 1'b0;
    #1;
    check("midrst_busy", {124'd0, busy}, 128'd0);
    check("midrst_resp", {120'd0, resp}, 128'd0);
    check("midrst_data", dout, 128'd0);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("post_rst_resp%0d", i), {120'd0, resp}, 128'd0);
      check($sformatf("post_rst_busy%0d", i), {124'd0, busy}, 128'd0);
    end
    run_single(tbl[0], 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
